// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
// Two-requester front end for sdram_controller. Requester 0 is the CPU
// (Wishbone) path, requester 1 the DMA/prefetch engine. One transaction is
// captured at a time, presented on the controller's single request port, and
// its write completion or read data is routed back to the requester that owns
// it. Ties are shared round-robin, with a bounded run of consecutive grants.

module sdram_req_arbiter #(
   parameter int ADDR_W     = 23,
   parameter int HOLD_MAX   = 4,
   parameter int RD_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic              m0_req_we,
   input  logic [ADDR_W-1:0] m0_req_addr,
   input  logic [31:0]       m0_req_wdata,
   input  logic [3:0]        m0_req_sel,
   output logic              m0_rsp_valid,
   output logic [31:0]       m0_rsp_rdata,
   output logic              m0_rsp_err,
   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic              m1_req_we,
   input  logic [ADDR_W-1:0] m1_req_addr,
   input  logic [31:0]       m1_req_wdata,
   input  logic [3:0]        m1_req_sel,
   output logic              m1_rsp_valid,
   output logic [31:0]       m1_rsp_rdata,
   output logic              m1_rsp_err,
   output logic              ctrl_in_valid,
   input  logic              ctrl_busy,
   output logic              ctrl_rw,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic [31:0]       ctrl_wdata,
   output logic [3:0]        ctrl_mask,
   input  logic              ctrl_out_valid,
   input  logic [31:0]       ctrl_rdata,
   output logic              grant_id,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } state_t;

   localparam logic [3:0]  HOLD_LIM = 4'(HOLD_MAX);
   localparam logic [15:0] TO_LAST  = 16'(RD_TIMEOUT - 1);

   state_t              state_q, state_d;
   logic                lastGrant_q, lastGrant_d;
   logic [3:0]          holdCnt_q, holdCnt_d;
   logic [15:0]         toCnt_q, toCnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          sel_q, sel_d;
   logic                grantId_q, grantId_d;
   logic                rspValid_q, rspValid_d;
   logic                rspId_q, rspId_d;
   logic                rspErr_q, rspErr_d;
   logic [31:0]         rspRdata_q, rspRdata_d;
   logic                winner;

   // Pick the winner among valid requesters; a zero hold count means nobody is
   // holding yet, so a tie falls straight to round-robin (m0 after reset).
   always_comb begin
      winner = m1_req_valid;
      if (m0_req_valid && m1_req_valid) begin
         if ((holdCnt_q != 4'd0) && (holdCnt_q < HOLD_LIM)) begin
            winner = lastGrant_q;
         end else begin
            winner = ~lastGrant_q;
         end
      end
   end

   // Next-state logic: capture in IDLE, present in ISSUE, collect in WAIT_RD.
   always_comb begin
      state_d      = state_q;
      lastGrant_d  = lastGrant_q;
      holdCnt_d    = holdCnt_q;
      toCnt_d      = toCnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      sel_d        = sel_q;
      grantId_d    = grantId_q;
      rspValid_d   = 1'b0;
      rspId_d      = rspId_q;
      rspErr_d     = 1'b0;
      rspRdata_d   = 32'h0;
      m0_req_ready = 1'b0;
      m1_req_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_req_valid || m1_req_valid) begin
               m0_req_ready = ~winner;
               m1_req_ready = winner;
               we_d         = winner ? m1_req_we    : m0_req_we;
               addr_d       = winner ? m1_req_addr  : m0_req_addr;
               wdata_d      = winner ? m1_req_wdata : m0_req_wdata;
               sel_d        = winner ? m1_req_sel   : m0_req_sel;
               grantId_d    = winner;
               if (winner == lastGrant_q) begin
                  holdCnt_d = (holdCnt_q == 4'd15) ? 4'd15 : holdCnt_q + 4'd1;
               end else begin
                  holdCnt_d = 4'd1;
               end
               lastGrant_d  = winner;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (!ctrl_busy) begin
               if (we_q) begin
                  rspValid_d = 1'b1;
                  rspId_d    = grantId_q;
                  state_d    = IDLE;
               end else begin
                  toCnt_d    = 16'd0;
                  state_d    = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (ctrl_out_valid) begin
               rspValid_d = 1'b1;
               rspId_d    = grantId_q;
               rspRdata_d = ctrl_rdata;
               state_d    = IDLE;
            end else begin
               toCnt_d = toCnt_q + 16'd1;
               if (toCnt_q == TO_LAST) begin
                  rspValid_d = 1'b1;
                  rspId_d    = grantId_q;
                  rspErr_d   = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (rst) begin
         m0_req_ready = 1'b0;
         m1_req_ready = 1'b0;
      end
   end

   // State and datapath registers; reset abandons any transaction silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         holdCnt_q   <= 4'd0;
         toCnt_q     <= 16'd0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         sel_q       <= 4'h0;
         grantId_q   <= 1'b0;
         rspValid_q  <= 1'b0;
         rspId_q     <= 1'b0;
         rspErr_q    <= 1'b0;
         rspRdata_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         holdCnt_q   <= holdCnt_d;
         toCnt_q     <= toCnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         sel_q       <= sel_d;
         grantId_q   <= grantId_d;
         rspValid_q  <= rspValid_d;
         rspId_q     <= rspId_d;
         rspErr_q    <= rspErr_d;
         rspRdata_q  <= rspRdata_d;
      end
   end

   assign ctrl_in_valid = (state_q == ISSUE);
   assign ctrl_rw       = we_q;
   assign ctrl_addr     = addr_q;
   assign ctrl_wdata    = wdata_q;
   assign ctrl_mask     = we_q ? sel_q : 4'h0;
   assign grant_id      = grantId_q;
   assign busy          = (state_q != IDLE);

   assign m0_rsp_valid  = rspValid_q & ~rspId_q;
   assign m0_rsp_rdata  = rspId_q ? 32'h0 : rspRdata_q;
   assign m0_rsp_err    = rspErr_q & ~rspId_q;
   assign m1_rsp_valid  = rspValid_q & rspId_q;
   assign m1_rsp_rdata  = rspId_q ? rspRdata_q : 32'h0;
   assign m1_rsp_err    = rspErr_q & rspId_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Testbench for sdram_req_arbiter: a table of single transactions plus
// hand-written sequences for reset-abort and continuous contention. Grants
// and responses are checked against scoreboard queues by a monitor.

module tb_sdram_req_arbiter;

   localparam int ADDR_W     = 23;
   localparam int HOLD_MAX   = 4;
   localparam int RD_TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_req_valid, m0_req_ready, m0_req_we;
   logic [ADDR_W-1:0] m0_req_addr;
   logic [31:0]       m0_req_wdata;
   logic [3:0]        m0_req_sel;
   logic              m0_rsp_valid, m0_rsp_err;
   logic [31:0]       m0_rsp_rdata;
   logic              m1_req_valid, m1_req_ready, m1_req_we;
   logic [ADDR_W-1:0] m1_req_addr;
   logic [31:0]       m1_req_wdata;
   logic [3:0]        m1_req_sel;
   logic              m1_rsp_valid, m1_rsp_err;
   logic [31:0]       m1_rsp_rdata;
   logic              ctrl_in_valid, ctrl_busy, ctrl_rw;
   logic [ADDR_W-1:0] ctrl_addr;
   logic [31:0]       ctrl_wdata;
   logic [3:0]        ctrl_mask;
   logic              ctrl_out_valid;
   logic [31:0]       ctrl_rdata;
   logic              grant_id, busy;

   int errors = 0;
   int checks = 0;

   bit          grantQ[$];
   logic [34:0] rspQ[$];

   typedef struct {
      bit          id;
      bit          we;
      logic [22:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          busyCyc;
      int          lat;
      logic [31:0] rdata;
      logic [3:0]  expMask;
      logic [31:0] expRdata;
      bit          expErr;
   } vec_t;

   vec_t vecs[8];

   sdram_req_arbiter #(
      .ADDR_W(ADDR_W), .HOLD_MAX(HOLD_MAX), .RD_TIMEOUT(RD_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
      .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_sel(m0_req_sel),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
      .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_sel(m1_req_sel),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
      .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy), .ctrl_rw(ctrl_rw),
      .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_mask(ctrl_mask),
      .ctrl_out_valid(ctrl_out_valid), .ctrl_rdata(ctrl_rdata),
      .grant_id(grant_id), .busy(busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Watchdog so the bench always ends even if the design stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic setReq(input bit id, input bit v, input bit we, input logic [22:0] a,
                         input logic [31:0] d, input logic [3:0] s);
      if (!id) begin
         m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d; m0_req_sel = s;
      end else begin
         m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d; m1_req_sel = s;
      end
   endtask

   function automatic bit readyOf(input bit id);
      return id ? m1_req_ready : m0_req_ready;
   endfunction

   function automatic bit rspOf(input bit id);
      return id ? m1_rsp_valid : m0_rsp_valid;
   endfunction

   // Scoreboard monitor: every ready pulse and response pulse is matched
   // against the next expected entry, sampled well clear of the clock edge.
   always @(negedge clk) begin
      bit          g;
      logic [34:0] e;
      #2;
      if (m0_req_ready || m1_req_ready) begin
         if (grantQ.size() == 0) begin
            checkOutput("unexpected_grant", {m1_req_ready, m0_req_ready}, 2'b00);
         end else begin
            g = grantQ.pop_front();
            checkOutput("grant_order", {m1_req_ready, m0_req_ready}, g ? 2'b10 : 2'b01);
         end
      end
      if (m0_rsp_valid || m1_rsp_valid) begin
         if (rspQ.size() == 0) begin
            checkOutput("unexpected_rsp", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
         end else begin
            e = rspQ.pop_front();
            checkOutput("rsp_content",
                        {m1_rsp_valid, m0_rsp_valid,
                         m1_rsp_valid ? m1_rsp_rdata : m0_rsp_rdata,
                         m1_rsp_valid ? m1_rsp_err : m0_rsp_err}, e);
         end
      end
   end

   task automatic checkFields(input vec_t v);
      checkOutput("ctrl_fields",
                  {ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_mask, grant_id, busy},
                  {1'b1, v.we, v.addr, v.wdata, v.expMask, v.id, 1'b1});
   endtask

   // One table transaction: request, optional controller back-pressure, then
   // controller read return (lat>0) or silence (lat=0) and response latency.
   task automatic applyStimulus(input vec_t v);
      int n;
      int expLat;
      bit seen;
      @(negedge clk);
      setReq(v.id, 1'b1, v.we, v.addr, v.wdata, v.sel);
      grantQ.push_back(v.id);
      rspQ.push_back({v.id ? 2'b10 : 2'b01, v.expRdata, v.expErr});
      #1;
      n = 0;
      while (!readyOf(v.id) && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("capture_wait", n, 0);
      @(negedge clk);
      setReq(v.id, 1'b0, ~v.we, ~v.addr, ~v.wdata, ~v.sel);
      ctrl_busy = (v.busyCyc != 0);
      #1;
      checkFields(v);
      for (int b = 1; b <= v.busyCyc; b++) begin
         @(negedge clk);
         ctrl_busy = (b < v.busyCyc);
         #1;
         checkFields(v);
      end
      expLat = v.we ? 1 : ((v.lat != 0) ? v.lat + 1 : RD_TIMEOUT + 1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 400) begin
         @(negedge clk);
         n++;
         ctrl_out_valid = (!v.we && v.lat != 0 && n == v.lat);
         ctrl_rdata     = ctrl_out_valid ? v.rdata : 32'hDEAD_BEEF;
         #1;
         if (n == 1) checkOutput("in_valid_drop", ctrl_in_valid, 1'b0);
         seen = rspOf(v.id);
      end
      ctrl_out_valid = 1'b0;
      checkOutput("rsp_latency", n, expLat);
   endtask

   initial begin
      int grants;
      vecs[0] = '{1'b0, 1'b1, 23'h000010, 32'hA5A5_0001, 4'hF,  0, 0, 32'h0,         4'hF, 32'h0,         1'b0};
      vecs[1] = '{1'b1, 1'b0, 23'h000020, 32'h0000_0000, 4'h3,  0, 6, 32'h1234_5678, 4'h0, 32'h1234_5678, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 23'h7FFFFF, 32'hFFFF_FFFF, 4'h5, 10, 0, 32'h0,         4'h5, 32'h0,         1'b0};
      vecs[3] = '{1'b1, 1'b1, 23'h000001, 32'h0000_0000, 4'hA,  2, 0, 32'h0,         4'hA, 32'h0,         1'b0};
      vecs[4] = '{1'b0, 1'b0, 23'h000100, 32'h1111_2222, 4'hF,  0, 0, 32'h0,         4'h0, 32'h0,         1'b1};
      vecs[5] = '{1'b0, 1'b0, 23'h000101, 32'h0,         4'hF,  3, 1, 32'hCAFE_F00D, 4'h0, 32'hCAFE_F00D, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 23'h3ABCDE, 32'h0,         4'h1,  0, 8, 32'h0BAD_C0DE, 4'h0, 32'h0BAD_C0DE, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 23'h000055, 32'h0,         4'hC,  0, 7, 32'h0000_0001, 4'h0, 32'h0000_0001, 1'b0};

      rst = 1'b1;
      setReq(1'b0, 1'b0, 1'b0, 23'h0, 32'h0, 4'h0);
      setReq(1'b1, 1'b0, 1'b0, 23'h0, 32'h0, 4'h0);
      ctrl_busy = 1'b0;
      ctrl_out_valid = 1'b0;
      ctrl_rdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_outputs",
                  {busy, grant_id, ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_mask,
                   m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err,
                   m0_rsp_rdata, m1_rsp_rdata}, 128'h0);
      rst = 1'b0;

      $display("[TB] table-driven transactions");
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Reset during WAIT_RD followed by a late controller return.
      $display("[TB] reset during WAIT_RD");
      @(negedge clk);
      setReq(1'b1, 1'b1, 1'b0, 23'h000055, 32'h0, 4'hF);
      grantQ.push_back(1'b1);
      @(negedge clk);
      setReq(1'b1, 1'b0, 1'b0, 23'h0, 32'h0, 4'h0);
      @(negedge clk);
      #1;
      checkOutput("in_wait_rd", {busy, ctrl_in_valid}, 2'b10);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("abort_outputs",
                  {busy, grant_id, ctrl_in_valid, m0_rsp_valid, m1_rsp_valid, m0_req_ready, m1_req_ready},
                  7'h0);
      @(negedge clk);
      rst = 1'b0;
      ctrl_out_valid = 1'b1;
      ctrl_rdata = 32'hFFFF_0000;
      @(negedge clk);
      ctrl_out_valid = 1'b0;
      #1;
      checkOutput("no_rsp_after_reset_a", {m1_rsp_valid, m0_rsp_valid, busy}, 3'b000);
      @(negedge clk);
      #1;
      checkOutput("no_rsp_after_reset_b", {m1_rsp_valid, m0_rsp_valid, busy}, 3'b000);

      // Continuous contention: both requesters write back to back.
      $display("[TB] continuous contention");
      for (int k = 0; k < 10; k++) begin
         bit g;
         g = (k >= 4 && k < 8);
         grantQ.push_back(g);
         rspQ.push_back({g ? 2'b10 : 2'b01, 32'h0, 1'b0});
      end
      grants = 0;
      for (int c = 0; c < 60 && grants < 10; c++) begin
         @(negedge clk);
         if (c == 0) begin
            setReq(1'b0, 1'b1, 1'b1, 23'h000A00, 32'h0000_AAAA, 4'hF);
            setReq(1'b1, 1'b1, 1'b1, 23'h000B00, 32'h0000_BBBB, 4'hF);
         end
         #1;
         if (m0_req_ready || m1_req_ready) grants++;
      end
      @(negedge clk);
      setReq(1'b0, 1'b0, 1'b0, 23'h0, 32'h0, 4'h0);
      setReq(1'b1, 1'b0, 1'b0, 23'h0, 32'h0, 4'h0);
      checkOutput("contention_grants", grants, 10);
      repeat (5) @(negedge clk);
      #3;
      checkOutput("grant_queue_drained", grantQ.size(), 0);
      checkOutput("rsp_queue_drained", rspQ.size(), 0);
      checkOutput("final_idle", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
